seq_det_scheduler: RTL
======================

SEQ_DET_SCHEDULER -- requirements
Module: seq_det_scheduler

Interface
REQ-001 Parameter NCH, default 4: number of serial requester channels; fixed at 4 in this revision.
REQ-002 Parameter CNT_W, default 8: width of each per-channel match counter.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  global enable; 0 = no grants, all state holds.
REQ-006 req  input  NCH  per-channel request: bit din[i] valid.
REQ-007 din  input  NCH  per-channel serial data bit.
REQ-008 gnt  output  NCH  one-hot grant, combinational; req[i]&gnt[i] = din[i] consumed this cycle.
REQ-009 clr_ch  input  1  clear request for channel clr_idx.
REQ-010 clr_idx  input  2  channel to clear.
REQ-011 rd_idx  input  2  counter read select.
REQ-012 det_vld  output  1  registered; a bit was processed last cycle.
REQ-013 det_ch  output  2  registered; channel processed last cycle.
REQ-014 det_hit  output  1  registered; pattern 000111 completed on det_ch.
REQ-015 rd_cnt  output  CNT_W  registered; match count of rd_idx.

Function
REQ-016 Block SHALL time-share one Mealy 000111 detector engine among NCH channels, holding a 3-bit saved state context per channel.
REQ-017 Context states SHALL be S0..S5 encoded 0..5; codes 6,7 SHALL behave as S0 with hit=0.
REQ-018 Transitions (x=din): S0: 1->S0, 0->S1; S1: 1->S0, 0->S2; S2: 1->S0, 0->S3; S3: 1->S4, 0->S3; S4: 1->S5, 0->S1; S5: 1->S0 with hit, 0->S1.
REQ-019 Hit SHALL be asserted only for S5 with x=1; detection is non-overlapping (next state S0).
REQ-020 Eligible channel i: req[i]=1, en=1, and not (clr_ch=1 and clr_idx=i).
REQ-021 Arbitration SHALL be round-robin: search eligible channels starting at pointer ptr, ascending mod NCH; first found is granted.
REQ-022 At most one gnt bit SHALL be high per cycle; gnt=0 when no eligible channel.
REQ-023 After a grant to channel g, ptr SHALL become (g+1) mod NCH; with no grant, ptr holds.
REQ-024 Granted channel's context SHALL update per REQ-018 at the clock edge; all other contexts hold.
REQ-025 det_vld/det_ch/det_hit SHALL reflect the grant of the previous cycle (latency 1); det_vld=0 and det_hit=0 when no grant; det_ch holds its value when det_vld=0.
REQ-026 On hit, counter of granted channel SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-027 clr_ch=1 SHALL set context[clr_idx]=S0 and counter[clr_idx]=0 at the edge; that channel is masked from grant that cycle (REQ-020), so clear never collides with a hit.
REQ-028 rd_cnt SHALL register counter[rd_idx] each cycle (1-cycle read latency), showing the counter value before the same-edge update.
REQ-029 en=0 SHALL block grants and context/counter/ptr updates; clr_ch SHALL still take effect; rd_cnt still updates.

Reset
REQ-030 With rst=1 at an edge: all contexts S0, all counters 0, ptr=0, det_vld=0, det_hit=0, det_ch=0, rd_cnt=0; gnt=0 combinationally while rst=1.
REQ-031 rst SHALL override clr_ch and en; reset mid-stream SHALL discard partial matches on all channels.

Verification
REQ-032 Single channel 0 streams 0,0,0,1,1,1 (req[0]=1 only) -> det_hit=1, det_ch=0 exactly one cycle after the sixth grant; counter[0]=1.
REQ-033 All four req high for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... ; each channel gets 2 bits; det_ch trails by one cycle.
REQ-034 Channels 0 and 1 interleaved by arbitration, each feeding 000111 -> both detect independently; counters 1 and 1; no cross-channel state corruption.
REQ-035 Stream 0001110111 on channel 2 -> one hit (non-overlapping); stream 0000111 -> one hit (S3 self-loop).
REQ-036 Drive 256 hits on channel 3 -> rd_cnt (rd_idx=3) reads 255, holds; then clr_ch with clr_idx=3 -> rd_cnt reads 0 two cycles later, channel 3 not granted that cycle.
REQ-037 Assert rst after 000 11 on channel 1, then send 1 -> no hit; then full 000111 -> hit; en=0 for 3 cycles with req high -> gnt=0, contexts unchanged.

Source files
------------

// File: rtl/seq_det_scheduler.sv
// Time-shared Mealy "000111" detector serving NCH serial channels.
// Round-robin grant picks one channel per cycle; its saved context drives the single engine.
module seq_det_scheduler #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   din,
  output logic [NCH-1:0]   gnt,
  input  logic             clr_ch,
  input  logic [1:0]       clr_idx,
  input  logic [1:0]       rd_idx,
  output logic             det_vld,
  output logic [1:0]       det_ch,
  output logic             det_hit,
  output logic [CNT_W-1:0] rd_cnt
);

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_t;

  state_t           ctx [NCH];
  logic [CNT_W-1:0] cnt [NCH];
  logic [1:0]       ptr;

  logic [NCH-1:0]   elig;
  logic             found;
  logic [1:0]       gidx;
  logic             x;
  state_t           cur;
  state_t           nxt;
  logic             hit;

  // A channel being cleared is masked so a clear can never coincide with its own hit.
  always_comb begin
    elig = (rst || !en) ? '0 : req;
    if (clr_ch) elig[clr_idx] = 1'b0;
  end

  // Round-robin search from ptr; the 2-bit sum wraps modulo NCH.
  always_comb begin
    found = 1'b0;
    gidx  = ptr;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (!found && elig[ptr + 2'(k)]) begin
        found = 1'b1;
        gidx  = ptr + 2'(k);
      end
    end
    gnt = '0;
    if (found) gnt[gidx] = 1'b1;
  end

  assign cur = ctx[gidx];
  assign x   = din[gidx];

  // Next-state logic of the shared engine; unused codes 6,7 act as S0.
  always_comb begin
    nxt = S0;
    case (cur)
      S0:      nxt = x ? S0 : S1;
      S1:      nxt = x ? S0 : S2;
      S2:      nxt = x ? S0 : S3;
      S3:      nxt = x ? S4 : S3;
      S4:      nxt = x ? S5 : S1;
      S5:      nxt = x ? S0 : S1;
      default: nxt = x ? S0 : S1;
    endcase
  end

  always_comb begin
    hit = found && (cur == S5) && x;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        ctx[i] <= S0;
        cnt[i] <= '0;
      end
      ptr     <= '0;
      det_vld <= 1'b0;
      det_hit <= 1'b0;
      det_ch  <= '0;
      rd_cnt  <= '0;
    end else begin
      rd_cnt  <= cnt[rd_idx];
      det_vld <= found;
      det_hit <= hit;
      if (found) begin
        det_ch    <= gidx;
        ctx[gidx] <= nxt;
        ptr       <= gidx + 2'd1;
        if (hit && (cnt[gidx] != '1)) cnt[gidx] <= cnt[gidx] + CNT_W'(1);
      end
      if (clr_ch) begin
        ctx[clr_idx] <= S0;
        cnt[clr_idx] <= '0;
      end
    end
  end

endmodule
